// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES mode controller.
//   state_e  : FSM state codes (binary encoded)
//   MODE_*   : meaning of the Mode request bit
//   AES_DATA_W : default block width
package aes_ctrl_pkg;

  localparam int AES_DATA_W = 128;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_CORE = 3'd2,
    ST_WAIT_RY   = 3'd3,
    ST_HOLD      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

endpackage

// File: rtl/aes_ctrl_watchdog.sv
// Saturating cycle counter guarding the controller's wait states.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_i     : synchronous active-high reset, clears the count
//   clear_i   : restart the count at the next edge (wins over enable_i)
//   enable_i  : count one cycle at the next edge
//   expired_o : the count reaches TIMEOUT_CYC at the coming edge
module aes_ctrl_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc_s;

  // Saturating increment of the current count.
  always_comb begin
    if (cnt_q == LIMIT) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CW'(1);
    end
  end

  // Next count: clear beats enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Expiry looks at the value the counter is about to take, so the FSM
  // leaves the wait state on exactly the edge where the count hits the
  // limit: a wait state lasts at most TIMEOUT_CYC cycles.
  assign expired_o = enable_i && !clear_i && (cnt_inc_s == LIMIT);

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_mode_controller.sv
// Sequences one AES operation: captures a request, launches the encrypt or
// decrypt core, waits for its done, runs the output selector until Ry, then
// holds the result (or a watchdog error) until the host acknowledges.
// Ports:
//   Clk, Rst            : clock, synchronous active-high reset
//   Start/Mode/DataIn   : host request (sampled in IDLE only)
//   Busy                : controller not idle
//   CoreData            : captured block to both cores
//   EncStart/DecStart   : one-cycle core launch pulses
//   EncDone/DecDone     : core completion
//   SelRst/SelOut/SelEn : output selector clear / Sel / En
//   SelRy/ResultIn      : selector ready and data
//   Result/Done/Err/Ack : host result, valid, watchdog error, acknowledge
module aes_mode_controller
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W      = AES_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Mode,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Busy,
  output logic [DATA_W-1:0] CoreData,
  output logic              EncStart,
  output logic              DecStart,
  input  logic              EncDone,
  input  logic              DecDone,
  output logic              SelRst,
  output logic              SelOut,
  output logic              SelEn,
  input  logic              SelRy,
  input  logic [DATA_W-1:0] ResultIn,
  output logic [DATA_W-1:0] Result,
  output logic              Done,
  output logic              Err,
  input  logic              Ack
);

  state_e              state_q;
  state_e              state_d;
  logic                mode_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   result_q;
  logic                busy_q;
  logic                enc_start_q;
  logic                dec_start_q;
  logic                sel_rst_q;
  logic                sel_en_q;
  logic                done_q;
  logic                err_q;

  logic                capture_s;
  logic                result_load_s;
  logic                core_done_s;
  logic                wd_clear_s;
  logic                wd_enable_s;
  logic                wd_expired_s;

  // Only the done of the core that was actually launched counts.
  assign core_done_s = (mode_q == MODE_ENC) ? EncDone : DecDone;

  // Restart the watchdog on entry to each wait state.
  assign wd_clear_s  = (state_q == ST_LAUNCH) ||
                       ((state_q == ST_WAIT_CORE) && core_done_s);
  assign wd_enable_s = (state_q == ST_WAIT_CORE) || (state_q == ST_WAIT_RY);

  aes_ctrl_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   (wd_clear_s),
    .enable_i  (wd_enable_s),
    .expired_o (wd_expired_s)
  );

  // Next-state logic plus capture / result-load strobes.
  always_comb begin
    state_d       = state_q;
    capture_s     = 1'b0;
    result_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_LAUNCH;
          capture_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (core_done_s) begin
          state_d = ST_WAIT_RY;
        end else if (wd_expired_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_WAIT_CORE;
        end
      end
      ST_WAIT_RY: begin
        // Ready is checked first so a late-but-valid result still lands.
        if (SelRy) begin
          state_d       = ST_HOLD;
          result_load_s = 1'b1;
        end else if (wd_expired_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_WAIT_RY;
        end
      end
      ST_HOLD: begin
        if (Ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ERROR: begin
        if (Ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, capture/result registers and outputs decoded from the next state
  // so every output changes on the same edge as the state it belongs to.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      data_q      <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      sel_rst_q   <= 1'b0;
      sel_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_s) begin
        mode_q <= Mode;
        data_q <= DataIn;
      end
      if (result_load_s) begin
        result_q <= ResultIn;
      end
      busy_q      <= (state_d != ST_IDLE);
      enc_start_q <= capture_s && (Mode == MODE_ENC);
      dec_start_q <= capture_s && (Mode == MODE_DEC);
      sel_rst_q   <= capture_s;
      sel_en_q    <= (state_d == ST_WAIT_RY);
      done_q      <= (state_d == ST_HOLD);
      err_q       <= (state_d == ST_ERROR);
    end
  end

  assign Busy     = busy_q;
  assign CoreData = data_q;
  assign EncStart = enc_start_q;
  assign DecStart = dec_start_q;
  assign SelRst   = sel_rst_q;
  assign SelOut   = mode_q;
  assign SelEn    = sel_en_q;
  assign Result   = result_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_aes_mode_controller.sv
// Directed bench: dut (TIMEOUT_CYC = 64) covers the normal paths and reset;
// dut_t (TIMEOUT_CYC = 8) shares all inputs except Start and covers expiry.
module tb_aes_mode_controller;

  localparam logic [127:0] BLK_A = 128'h03c18e199ba5296289328eca914a59aa;
  localparam logic [127:0] BLK_B = 128'h5b448dd8c1beb2c7653f07f878c2c8e0;
  localparam logic [127:0] BLK_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_D = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] BLK_E = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] BLK_F = 128'hdeadbeefcafef00d0badc0de12345678;

  logic         Clk = 1'b0;
  logic         Rst, Start, start_t, Mode, EncDone, DecDone, SelRy, Ack;
  logic [127:0] DataIn, ResultIn;

  logic         Busy, EncStart, DecStart, SelRst, SelOut, SelEn, Done, Err;
  logic [127:0] CoreData, Result;
  logic         busy_t, enc_start_t, dec_start_t, sel_rst_t, sel_out_t, sel_en_t, done_t, err_t;
  logic [127:0] core_data_t, result_t;

  int n_cmp = 0;
  int n_err = 0;
  logic dec_seen;

  always #5 Clk = ~Clk;

  aes_mode_controller #(.DATA_W(128), .TIMEOUT_CYC(64)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .DataIn(DataIn),
    .Busy(Busy), .CoreData(CoreData), .EncStart(EncStart), .DecStart(DecStart),
    .EncDone(EncDone), .DecDone(DecDone), .SelRst(SelRst), .SelOut(SelOut),
    .SelEn(SelEn), .SelRy(SelRy), .ResultIn(ResultIn), .Result(Result),
    .Done(Done), .Err(Err), .Ack(Ack)
  );

  aes_mode_controller #(.DATA_W(128), .TIMEOUT_CYC(8)) dut_t (
    .Clk(Clk), .Rst(Rst), .Start(start_t), .Mode(Mode), .DataIn(DataIn),
    .Busy(busy_t), .CoreData(core_data_t), .EncStart(enc_start_t), .DecStart(dec_start_t),
    .EncDone(EncDone), .DecDone(DecDone), .SelRst(sel_rst_t), .SelOut(sel_out_t),
    .SelEn(sel_en_t), .SelRy(SelRy), .ResultIn(ResultIn), .Result(result_t),
    .Done(done_t), .Err(err_t), .Ack(Ack)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; start_t = 1'b0; Mode = 1'b0; EncDone = 1'b0;
    DecDone = 1'b0; SelRy = 1'b0; Ack = 1'b0; DataIn = '0; ResultIn = '0;
    tick(); tick();
    // Reset state
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_err", Err, 1'b0);
    chk1("rst_selout", SelOut, 1'b0);
    chkw("rst_result", Result, '0);
    chkw("rst_coredata", CoreData, '0);
    Rst = 1'b0;
    tick();

    // ---------------- Encrypt path ----------------
    Mode = 1'b1; DataIn = BLK_A; Start = 1'b1;
    tick();
    Start = 1'b0; DataIn = '0;
    dec_seen = DecStart;
    chk1("enc_launch_encstart", EncStart, 1'b1);
    chk1("enc_launch_selrst", SelRst, 1'b1);
    chk1("enc_launch_busy", Busy, 1'b1);
    chkw("enc_coredata", CoreData, BLK_A);
    chk1("enc_selout", SelOut, 1'b1);
    tick();
    dec_seen = dec_seen | DecStart;
    chk1("enc_pulse_one_cycle", EncStart, 1'b0);
    chk1("enc_selrst_one_cycle", SelRst, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      dec_seen = dec_seen | DecStart;
    end
    chk1("enc_no_selen_early", SelEn, 1'b0);
    EncDone = 1'b1;
    tick();
    EncDone = 1'b0;
    chk1("enc_selen", SelEn, 1'b1);
    chk1("enc_selout_ry", SelOut, 1'b1);
    chk1("enc_done_early", Done, 1'b0);
    ResultIn = BLK_B; SelRy = 1'b1;
    tick();
    SelRy = 1'b0; ResultIn = '0;
    chk1("enc_done", Done, 1'b1);
    chkw("enc_result", Result, BLK_B);
    chk1("enc_selen_off", SelEn, 1'b0);
    tick(); tick();
    chk1("enc_done_held", Done, 1'b1);
    chkw("enc_result_held", Result, BLK_B);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk1("enc_ack_done", Done, 1'b0);
    chk1("enc_ack_busy", Busy, 1'b0);
    chk1("enc_decstart_never", dec_seen, 1'b0);

    // ---------------- Decrypt path ----------------
    Mode = 1'b0; DataIn = BLK_B; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk1("dec_launch_decstart", DecStart, 1'b1);
    chk1("dec_launch_encstart", EncStart, 1'b0);
    chk1("dec_selout", SelOut, 1'b0);
    tick(); tick(); tick();
    DecDone = 1'b1;
    tick();
    DecDone = 1'b0;
    chk1("dec_selen", SelEn, 1'b1);
    chk1("dec_done_early", Done, 1'b0);
    ResultIn = BLK_A; SelRy = 1'b1;
    tick();
    SelRy = 1'b0; ResultIn = '0;
    chk1("dec_done", Done, 1'b1);
    chkw("dec_result", Result, BLK_A);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk1("dec_ack_busy", Busy, 1'b0);

    // ---------------- Wrong done and busy Start ----------------
    Mode = 1'b1; DataIn = BLK_C; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    DecDone = 1'b1;
    tick();
    DecDone = 1'b0;
    chk1("wrong_done_selen", SelEn, 1'b0);
    chk1("wrong_done_busy", Busy, 1'b1);
    Start = 1'b1; DataIn = BLK_D; Mode = 1'b0;
    tick();
    Start = 1'b0; Mode = 1'b1;
    chkw("busy_start_coredata", CoreData, BLK_C);
    chk1("busy_start_no_enc", EncStart, 1'b0);
    chk1("busy_start_no_dec", DecStart, 1'b0);
    tick();
    chk1("busy_start_no_selrst", SelRst, 1'b0);
    chk1("busy_start_selen", SelEn, 1'b0);
    EncDone = 1'b1;
    tick();
    EncDone = 1'b0;
    chk1("wrong_then_right_selen", SelEn, 1'b1);
    ResultIn = BLK_E; SelRy = 1'b1;
    tick();
    SelRy = 1'b0;
    chk1("wrong_then_right_done", Done, 1'b1);
    chkw("wrong_then_right_result", Result, BLK_E);
    // Start together with Ack must not launch.
    Ack = 1'b1; Start = 1'b1;
    tick();
    Ack = 1'b0; Start = 1'b0;
    chk1("ack_start_busy", Busy, 1'b0);
    chk1("ack_start_no_launch", EncStart, 1'b0);
    tick();
    chk1("ack_start_still_idle", Busy, 1'b0);

    // ---------------- Expiry on dut_t (TIMEOUT_CYC = 8) ----------------
    // SelRy on the expiry edge of WAIT_RY gives Done.
    Mode = 1'b1; DataIn = BLK_C; start_t = 1'b1;
    tick();
    start_t = 1'b0;
    tick();
    EncDone = 1'b1;
    tick();
    EncDone = 1'b0;
    chk1("tie_selen", sel_en_t, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    ResultIn = BLK_F; SelRy = 1'b1;
    tick();
    SelRy = 1'b0; ResultIn = '0;
    chk1("tie_done", done_t, 1'b1);
    chk1("tie_err", err_t, 1'b0);
    chkw("tie_result", result_t, BLK_F);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;

    // WAIT_CORE timeout: 8 cycles in WAIT_CORE then ERROR.
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk1("tmo_core_not_yet", err_t, 1'b0);
    tick();
    chk1("tmo_core_err", err_t, 1'b1);
    chk1("tmo_core_busy", busy_t, 1'b1);
    chkw("tmo_core_result", result_t, BLK_F);
    tick();
    chk1("tmo_core_err_held", err_t, 1'b1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk1("tmo_core_ack_err", err_t, 1'b0);
    chk1("tmo_core_ack_busy", busy_t, 1'b0);

    // WAIT_RY timeout with SelRy held low.
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    tick();
    EncDone = 1'b1;
    tick();
    EncDone = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk1("tmo_ry_not_yet", err_t, 1'b0);
    tick();
    chk1("tmo_ry_err", err_t, 1'b1);
    chk1("tmo_ry_selen_off", sel_en_t, 1'b0);
    chk1("tmo_ry_done", done_t, 1'b0);
    chkw("tmo_ry_result", result_t, BLK_F);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk1("tmo_ry_ack_busy", busy_t, 1'b0);

    // ---------------- Reset mid-operation ----------------
    Mode = 1'b1; DataIn = BLK_A; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    EncDone = 1'b1;
    tick();
    EncDone = 1'b0;
    chk1("mid_rst_in_wait_ry", SelEn, 1'b1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk1("mid_rst_busy", Busy, 1'b0);
    chk1("mid_rst_selen", SelEn, 1'b0);
    chk1("mid_rst_selout", SelOut, 1'b0);
    chk1("mid_rst_done", Done, 1'b0);
    chk1("mid_rst_err", Err, 1'b0);
    chk1("mid_rst_encstart", EncStart, 1'b0);
    chk1("mid_rst_selrst", SelRst, 1'b0);
    chkw("mid_rst_coredata", CoreData, '0);
    chkw("mid_rst_result", Result, '0);
    SelRy = 1'b1; EncDone = 1'b1; ResultIn = BLK_E;
    tick();
    SelRy = 1'b0; EncDone = 1'b0; ResultIn = '0;
    chk1("post_rst_ignore_busy", Busy, 1'b0);
    chk1("post_rst_ignore_done", Done, 1'b0);
    Mode = 1'b0; DataIn = BLK_D; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk1("post_rst_decstart", DecStart, 1'b1);
    tick();
    DecDone = 1'b1;
    tick();
    DecDone = 1'b0;
    ResultIn = BLK_C; SelRy = 1'b1;
    tick();
    SelRy = 1'b0;
    chk1("post_rst_done", Done, 1'b1);
    chkw("post_rst_result", Result, BLK_C);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk1("post_rst_idle", Busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_mode_controller.md
Name: aes_mode_controller

Overview:
Sequences one AES operation at a time through the encrypt core, decrypt core and the 128-bit output selector (PT/CT mux with En/Ry).
- Accepts a request (mode + 128-bit block) from the host side.
- Launches the matching core and waits for its done.
- Drives the selector's Sel/En/Rst, waits for Ry, then registers and holds the result until the host acknowledges.
- Includes a watchdog so a hung core or selector cannot stall the host.

Parameters:
- DATA_W, 128, block width of DataIn/CoreData/ResultIn/Result.
- TIMEOUT_CYC, 64, maximum cycles allowed in WAIT_CORE or WAIT_RY before entering ERROR; legal range 1..1023.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Mode  in  1  1 = encrypt (result from CT), 0 = decrypt (result from PT); captured with Start.
- DataIn  in  DATA_W  input block; captured with Start.
- Busy  out  1  high in every state except IDLE.
- CoreData  out  DATA_W  captured block, driven to both cores.
- EncStart  out  1  one-cycle launch pulse to the encrypt core.
- DecStart  out  1  one-cycle launch pulse to the decrypt core.
- EncDone  in  1  encrypt core finished; CT valid.
- DecDone  in  1  decrypt core finished; PT valid.
- SelRst  out  1  one-cycle clear pulse to the output selector.
- SelOut  out  1  selector Sel; equals the captured Mode.
- SelEn  out  1  selector En.
- SelRy  in  1  selector Ry.
- ResultIn  in  DATA_W  selector Result.
- Result  out  DATA_W  registered result.
- Done  out  1  Result valid; held until Ack.
- Err  out  1  watchdog fired; held until Ack.
- Ack  in  1  host consumes Done or Err.

Behaviour:
- Reset (Rst = 1 at a rising edge, any state, including mid-operation):
  - State goes to IDLE.
  - All outputs are 0, including Result, CoreData and SelOut.
  - Watchdog counter clears.
  - Core done inputs and SelRy arriving in the cycle after reset are ignored.
- States: IDLE, LAUNCH, WAIT_CORE, WAIT_RY, HOLD, ERROR.
- IDLE:
  - Start = 1 captures Mode and DataIn, then goes to LAUNCH.
  - Start in any other state is ignored, with no queuing.
- LAUNCH (exactly one cycle):
  - EncStart = Mode, DecStart = ~Mode, SelRst = 1.
  - CoreData is valid from this cycle until return to IDLE.
  - Next state is WAIT_CORE; watchdog counter clears.
- WAIT_CORE:
  - Waits for the done of the launched core only; the other core's done is ignored.
  - On the matching done, go to WAIT_RY and clear the counter.
  - If the counter reaches TIMEOUT_CYC first, go to ERROR.
- WAIT_RY:
  - SelEn = 1 and SelOut = Mode for every cycle in this state.
  - If SelRy = 1 at an edge, register ResultIn into Result and go to HOLD.
  - If the counter reaches TIMEOUT_CYC first, go to ERROR.
  - If SelRy and timeout occur in the same cycle, SelRy wins.
- HOLD:
  - Done = 1, SelEn = 0; Result is stable.
  - Ack = 1 goes to IDLE; Done drops in the next cycle.
  - Start in the same cycle as Ack is ignored; the host re-asserts it in IDLE.
- ERROR:
  - Err = 1; Result is left unchanged.
  - Ack = 1 goes to IDLE.
- Latency:
  - Start sampled at edge t0 gives EncStart/DecStart high in cycle t0+1.
  - Core done sampled at edge d gives SelEn high from cycle d+1.
  - With SelRy high at edge d+1, Done rises in cycle d+2.
- Watchdog counter:
  - Width is clog2(TIMEOUT_CYC+1).
  - Increments once per cycle in WAIT_CORE and WAIT_RY, saturating.
  - Compare is equality with TIMEOUT_CYC.
- Busy = (state != IDLE). EncStart, DecStart and SelRst are never high outside LAUNCH.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum (6 codes, binary),
  - MODE_DEC = 1'b0 and MODE_ENC = 1'b1,
  - DATA_W default constant.
- One sub-module, aes_ctrl_watchdog:
  - clear/enable inputs, saturating counter, `expired` output, parameter TIMEOUT_CYC.
- FSM, capture registers and result register stay in the top module.

Test Plan:
- Encrypt path:
  - Stimulus: Mode = 1, DataIn = 03c18e199ba5296289328eca914a59aa, EncDone after 10 cycles, ResultIn = 5b448dd8c1beb2c7653f07f878c2c8e0, SelRy 1 cycle after SelEn.
  - Response: one-cycle EncStart; DecStart never high; SelOut = 1; Done high with Result = 5b448dd8…c8e0 until Ack; IDLE one cycle after Ack.
- Decrypt path:
  - Stimulus: Mode = 0, DataIn = 5b448dd8c1beb2c7653f07f878c2c8e0, DecDone, ResultIn = 03c18e199ba5296289328eca914a59aa.
  - Response: DecStart pulse; SelOut = 0; Result = 03c18e19…59aa; Done rises exactly 2 cycles after DecDone is sampled.
- Wrong done and busy Start:
  - Stimulus: Mode = 1 with DecDone pulsed in WAIT_CORE; Start = 1 during WAIT_CORE with different DataIn.
  - Response: state stays in WAIT_CORE; CoreData unchanged; no second launch.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 8, no EncDone.
  - Response: Err rises 8 cycles after entering WAIT_CORE; Result unchanged; Ack returns to IDLE with Busy = 0.
  - Repeat with SelRy held 0: Err fires from WAIT_RY. SelRy and expiry in the same cycle gives Done, not Err.
- Reset mid-operation:
  - Stimulus: Rst = 1 for one cycle while in WAIT_RY.
  - Response: next cycle all outputs are 0 and state is IDLE; a following Start completes normally.
